// File: rtl/elastic_link_buffer_if.sv
// rtl/elastic_link_buffer_if.sv - req/ack/packet link bundle for elastic_link_buffer
//
// Purpose : carries one point-to-point packet link. A transfer happens on a
//           rising clock edge where req and ack are both high.
// Signals : req    - sender has a valid packet on the link
//           ack    - receiver takes the packet this cycle
//           packet - PACKET_WIDTH-bit payload, meaningful while req is high
// Modports: sender   drives req/packet, observes ack
//           receiver observes req/packet, drives ack
interface link_if #(
    parameter int PACKET_WIDTH = 8
);
    logic                    req;
    logic                    ack;
    logic [PACKET_WIDTH-1:0] packet;

    modport sender (
        output req,
        output packet,
        input  ack
    );

    modport receiver (
        input  req,
        input  packet,
        output ack
    );
endinterface

// File: rtl/elastic_link_buffer.sv
// rtl/elastic_link_buffer.sv - store-and-forward elastic packet buffer between two req/ack links
//
// Purpose : FIFO_DEPTH-slot packet FIFO between an upstream and a downstream
//           req/ack link. One-cycle store-and-forward latency by default.
//           Optional feature macro: TIA_LINK_BUFFER_BYPASS_EN
//           (when defined, an empty buffer passes the upstream packet straight
//           through to the downstream link in the same cycle).
// Params  : FIFO_DEPTH        - packet slot count, >= 2, any integer
//           ALMOST_FULL_LEVEL - occupancy at or above which almost_full is high
//           PACKET_WIDTH      - packet payload width (must match the link_if)
// Ports   : clock       - positive-edge clock
//           reset       - asynchronous active-high reset of pointers/count
//           enable      - gates all transfers; low holds all state
//           flush       - synchronous discard of all buffered packets
//           quiescent   - buffer holds no packets
//           occupancy   - current packet count
//           almost_full - occupancy >= ALMOST_FULL_LEVEL
//           input_link  - upstream link (this block receives)
//           output_link - downstream link (this block sends)

`ifndef TIA_LINK_BUFFER_FIFO_DEPTH
`define TIA_LINK_BUFFER_FIFO_DEPTH 4
`endif

module elastic_link_buffer #(
    parameter int FIFO_DEPTH        = `TIA_LINK_BUFFER_FIFO_DEPTH,
    parameter int ALMOST_FULL_LEVEL = FIFO_DEPTH - 1,
    parameter int PACKET_WIDTH      = 8
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              enable,
    input  logic                              flush,
    output logic                              quiescent,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   occupancy,
    output logic                              almost_full,
    link_if.receiver                          input_link,
    link_if.sender                            output_link
);

    localparam int OCC_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(FIFO_DEPTH);
    localparam logic [OCC_W-1:0] OCC_AF   = OCC_W'(ALMOST_FULL_LEVEL);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);

    // Illegal configurations stop elaboration.
    generate
        if (FIFO_DEPTH < 2) begin : g_bad_depth
            $error("elastic_link_buffer: FIFO_DEPTH must be >= 2");
        end
        if ((ALMOST_FULL_LEVEL < 1) || (ALMOST_FULL_LEVEL > FIFO_DEPTH)) begin : g_bad_af
            $error("elastic_link_buffer: ALMOST_FULL_LEVEL must be in 1..FIFO_DEPTH");
        end
    endgenerate

    // Packet slots are never reset; head/tail/count alone define validity.
    logic [PACKET_WIDTH-1:0] slots [FIFO_DEPTH];

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [OCC_W-1:0] count;

    logic is_empty;
    logic is_full;
    logic in_ack;
    logic out_req;
    logic [PACKET_WIDTH-1:0] out_packet;
    logic bypass_active;
    logic push;
    logic pop;
    logic store;
    logic release_slot;

    assign is_empty = (count == '0);
    assign is_full  = (count == OCC_FULL);

    // Upstream ack depends only on local state and upstream req, so the
    // downstream ack never ripples back to the upstream link.
    assign in_ack = input_link.req && enable && !flush && !is_full;

`ifdef TIA_LINK_BUFFER_BYPASS_EN
    // An empty buffer offers the arriving packet downstream in the same cycle.
    assign bypass_active = is_empty && enable && !flush && input_link.req;
    assign out_req       = enable && !flush && (!is_empty || bypass_active);
    assign out_packet    = bypass_active ? input_link.packet : slots[head];
`else
    assign bypass_active = 1'b0;
    assign out_req       = enable && !flush && !is_empty;
    assign out_packet    = slots[head];
`endif

    assign push = input_link.req && in_ack;
    assign pop  = out_req && output_link.ack;

    // A bypassed packet that is taken downstream in the same cycle never
    // touches the slots; otherwise accepted packets are stored at the tail
    // and completed output transfers free the head slot.
    assign store        = push && !(bypass_active && pop);
    assign release_slot = pop && !bypass_active;

    assign input_link.ack     = in_ack;
    assign output_link.req    = out_req;
    assign output_link.packet = out_packet;

    assign occupancy   = count;
    assign quiescent   = is_empty;
    assign almost_full = (count >= OCC_AF);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (store) begin
                tail <= (tail == PTR_LAST) ? '0 : tail + 1'b1;
            end
            if (release_slot) begin
                head <= (head == PTR_LAST) ? '0 : head + 1'b1;
            end
            if (store && !release_slot) begin
                count <= count + 1'b1;
            end else if (release_slot && !store) begin
                count <= count - 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (store) begin
            slots[tail] <= input_link.packet;
        end
    end

endmodule

// File: tb/tb_elastic_link_buffer.sv
// tb/tb_elastic_link_buffer.sv - self-checking bench for elastic_link_buffer
module tb_elastic_link_buffer;

    localparam int DEPTH = 3;
    localparam int AFL   = DEPTH - 1;
    localparam int PW    = 8;
`ifdef TIA_LINK_BUFFER_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        flush = 1'b0;
    logic        quiescent;
    logic [1:0]  occupancy;
    logic        almost_full;

    link_if #(.PACKET_WIDTH(PW)) in_l ();
    link_if #(.PACKET_WIDTH(PW)) out_l ();

    elastic_link_buffer #(
        .FIFO_DEPTH(DEPTH),
        .ALMOST_FULL_LEVEL(AFL),
        .PACKET_WIDTH(PW)
    ) dut (
        .clock(clock),
        .reset(reset),
        .enable(enable),
        .flush(flush),
        .quiescent(quiescent),
        .occupancy(occupancy),
        .almost_full(almost_full),
        .input_link(in_l.receiver),
        .output_link(out_l.sender)
    );

    always #5 clock = ~clock;

    int vectors = 0;
    int miscompares = 0;

    logic [PW-1:0] model_q[$];
    logic [PW-1:0] dut_log[$];

    typedef struct {
        bit          en;
        bit          fl;
        bit          rq;
        logic [7:0]  pk;
        bit          oa;
        bit          x_in_ack;
        bit          x_out_req;
        logic [7:0]  x_pkt;
        int          x_occ;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input bit en, input bit fl, input bit rq, input logic [7:0] pk, input bit oa);
        enable      = en;
        flush       = fl;
        in_l.req    = rq;
        in_l.packet = pk;
        out_l.ack   = oa;
    endtask

    // Reference: a queue of buffered packets; outputs follow from its size
    // and the current inputs.
    task automatic check_model(input string tag);
        int  n;
        bit  x_ack;
        bit  x_req;
        logic [7:0] x_pkt;
        n     = model_q.size();
        x_ack = in_l.req && enable && !flush && (n < DEPTH);
        x_req = enable && !flush && ((n > 0) || (BYP && in_l.req));
        x_pkt = (n > 0) ? model_q[0] : in_l.packet;
        chk({tag, ".in_ack"}, int'(in_l.ack), int'(x_ack));
        chk({tag, ".out_req"}, int'(out_l.req), int'(x_req));
        if (x_req) chk({tag, ".packet"}, int'(out_l.packet), int'(x_pkt));
        chk({tag, ".occupancy"}, int'(occupancy), n);
        chk({tag, ".quiescent"}, int'(quiescent), int'(n == 0));
        chk({tag, ".almost_full"}, int'(almost_full), int'(n >= AFL));
    endtask

    task automatic model_edge();
        int n;
        bit acc;
        bit rel;
        n   = model_q.size();
        acc = in_l.req && enable && !flush && (n < DEPTH);
        rel = enable && !flush && ((n > 0) || (BYP && in_l.req)) && out_l.ack;
        if (flush) begin
            model_q.delete();
        end else begin
            if (rel) begin
                if (n > 0) void'(model_q.pop_front());
                else acc = 1'b0;
            end
            if (acc) model_q.push_back(in_l.packet);
        end
    endtask

    // One clock cycle: inputs applied just after an edge, checked mid-cycle.
    task automatic cycle(input bit en, input bit fl, input bit rq, input logic [7:0] pk, input bit oa, input string tag);
        drive(en, fl, rq, pk, oa);
        #4;
        check_model(tag);
        if (out_l.req && out_l.ack) dut_log.push_back(out_l.packet);
        @(posedge clock);
        model_edge();
        #1;
    endtask

    initial begin
        in_l.req = 1'b0; in_l.packet = '0; out_l.ack = 1'b0;

        // Push A,B,C,D into a depth-3 buffer with downstream stalled, hold with
        // enable low, drain one, refill, then flush with req high both sides.
        tbl[0]  = '{1,0,1,8'hA0,0, 1,BYP,8'hA0,0};
        tbl[1]  = '{1,0,1,8'hB1,0, 1,1,8'hA0,1};
        tbl[2]  = '{1,0,1,8'hC2,0, 1,1,8'hA0,2};
        tbl[3]  = '{1,0,1,8'hD3,0, 0,1,8'hA0,3};
        tbl[4]  = '{0,0,1,8'hD3,1, 0,0,8'h00,3};
        tbl[5]  = '{0,0,1,8'hD3,1, 0,0,8'h00,3};
        tbl[6]  = '{0,0,1,8'hD3,1, 0,0,8'h00,3};
        tbl[7]  = '{0,0,1,8'hD3,1, 0,0,8'h00,3};
        tbl[8]  = '{1,0,1,8'hD3,1, 0,1,8'hA0,3};
        tbl[9]  = '{1,0,1,8'hD3,1, 1,1,8'hB1,2};
        tbl[10] = '{1,1,1,8'hE4,1, 0,0,8'h00,2};
        tbl[11] = '{1,0,0,8'h00,0, 0,0,8'h00,0};

        repeat (2) @(posedge clock);
        #1;
        chk("reset.occupancy", int'(occupancy), 0);
        chk("reset.quiescent", int'(quiescent), 1);
        chk("reset.almost_full", int'(almost_full), 0);
        chk("reset.out_req", int'(out_l.req), 0);
        reset = 1'b0;

        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].en, tbl[i].fl, tbl[i].rq, tbl[i].pk, tbl[i].oa);
            #4;
            chk($sformatf("tbl%0d.in_ack", i), int'(in_l.ack), int'(tbl[i].x_in_ack));
            chk($sformatf("tbl%0d.out_req", i), int'(out_l.req), int'(tbl[i].x_out_req));
            if (tbl[i].x_out_req)
                chk($sformatf("tbl%0d.packet", i), int'(out_l.packet), int'(tbl[i].x_pkt));
            chk($sformatf("tbl%0d.occupancy", i), int'(occupancy), tbl[i].x_occ);
            chk($sformatf("tbl%0d.quiescent", i), int'(quiescent), int'(tbl[i].x_occ == 0));
            chk($sformatf("tbl%0d.almost_full", i), int'(almost_full), int'(tbl[i].x_occ >= AFL));
            @(posedge clock);
            model_edge();
            #1;
        end

        // Continuous push/pop of 10 packets: arrival order out, pointers wrap.
        dut_log.delete();
        for (int i = 0; i < 10; i++) cycle(1, 0, 1, 8'(i), 1, $sformatf("stream%0d", i));
        chk("stream.steady_occ", int'(occupancy), BYP ? 0 : 1);
        for (int i = 0; i < 3; i++) cycle(1, 0, 0, 8'h00, 1, "drain");
        chk("stream.count", dut_log.size(), 10);
        for (int i = 0; i < 10 && i < dut_log.size(); i++)
            chk($sformatf("stream.order%0d", i), int'(dut_log[i]), i);

        // Latency from an empty buffer with downstream ready.
        drive(1, 0, 1, 8'h5A, 1);
        #4;
        chk("latency.same_cycle_req", int'(out_l.req), int'(BYP));
        if (BYP) chk("latency.same_cycle_pkt", int'(out_l.packet), 8'h5A);
        @(posedge clock);
        model_edge();
        #1;
        cycle(1, 0, 0, 8'h00, 1, "latency.next");

        // Asynchronous reset between edges with two packets held.
        cycle(1, 0, 1, 8'h11, 0, "rst_fill0");
        cycle(1, 0, 1, 8'h22, 0, "rst_fill1");
        drive(1, 0, 1, 8'h33, 1);
        #2;
        chk("async_rst.pre_occ", int'(occupancy), 2);
        reset = 1'b1;
        #1;
        chk("async_rst.occupancy", int'(occupancy), 0);
        chk("async_rst.out_req", int'(out_l.req), int'(BYP));
        chk("async_rst.quiescent", int'(quiescent), 1);
        drive(1, 0, 0, 8'h00, 0);
        #1;
        chk("async_rst.out_req_idle", int'(out_l.req), 0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        model_q.delete();

        // Randomised traffic against the queue model.
        for (int i = 0; i < 1500; i++) begin
            cycle(($urandom_range(0, 7) != 0), ($urandom_range(0, 31) == 0),
                  $urandom_range(0, 1), 8'($urandom), $urandom_range(0, 1),
                  $sformatf("rand%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/elastic_link_buffer.md
ELASTIC_LINK_BUFFER -- requirements
Module: elastic_link_buffer

Interface
REQ-001 Parameter SHALL be: FIFO_DEPTH, TIA_LINK_BUFFER_FIFO_DEPTH, packet slot count; any integer >= 2, power of two not required.
REQ-002 Parameter SHALL be: ALMOST_FULL_LEVEL, FIFO_DEPTH - 1, occupancy at or above which almost_full asserts; legal range 1..FIFO_DEPTH.
REQ-003 Port SHALL be: clock  input  1  single clock, positive-edge triggered.
REQ-004 Port SHALL be: reset  input  1  asynchronous, active-high reset.
REQ-005 Port SHALL be: enable  input  1  active-high; gates all transfers.
REQ-006 Port SHALL be: flush  input  1  synchronous, active-high discard of all buffered packets.
REQ-007 Port SHALL be: quiescent  output  1  high when buffer holds no packets.
REQ-008 Port SHALL be: occupancy  output  $clog2(FIFO_DEPTH+1)  current packet count.
REQ-009 Port SHALL be: almost_full  output  1  occupancy >= ALMOST_FULL_LEVEL.
REQ-010 Port SHALL be: input_link  link_if.receiver  packet_t+2  upstream req/ack/packet.
REQ-011 Port SHALL be: output_link  link_if.sender  packet_t+2  downstream req/ack/packet.

Function
REQ-012 A transfer on a link SHALL occur exactly in a cycle where req and ack are both high at the rising clock edge.
REQ-013 input_link.ack SHALL be combinational: input_link.req && enable && !flush && occupancy != FIFO_DEPTH; no path from output_link.ack to input_link.ack.
REQ-014 output_link.req SHALL be enable && !flush && occupancy != 0 (bypass term per REQ-026); output_link.packet SHALL be the head slot.
REQ-015 Accepted packet SHALL be written at tail; tail advances by one, wrapping FIFO_DEPTH-1 -> 0.
REQ-016 Completed output transfer SHALL advance head by one, wrapping FIFO_DEPTH-1 -> 0.
REQ-017 Simultaneous accept and release: head and tail both advance, occupancy unchanged, including when occupancy == FIFO_DEPTH is impossible (ack low) and occupancy == 1.
REQ-018 Occupancy SHALL change by +1 (accept only), -1 (release only), 0 otherwise; never exceeds FIFO_DEPTH nor underflows.
REQ-019 Store-and-forward latency SHALL be one cycle: packet accepted at edge N is offered on output_link from cycle N+1.
REQ-020 Packets SHALL leave in arrival order with no duplication or loss.
REQ-021 flush high at an edge SHALL set head, tail, occupancy to 0 regardless of enable; no transfer occurs in a flush cycle.
REQ-022 enable low SHALL hold all state; both acks/reqs low per REQ-013/014.
REQ-023 quiescent SHALL equal occupancy == 0; almost_full SHALL be combinational from occupancy.
REQ-024 Elaboration SHALL fail if FIFO_DEPTH < 2 or ALMOST_FULL_LEVEL outside 1..FIFO_DEPTH.

Reset
REQ-025 reset high SHALL asynchronously clear head, tail, occupancy to 0, giving quiescent=1, almost_full=0, output_link.req=0; slot contents not cleared; reset mid-transfer discards all packets.

Configuration
REQ-026 With macro TIA_LINK_BUFFER_BYPASS_EN defined: when occupancy == 0, enable, !flush and input_link.req, output_link.req SHALL be 1 and output_link.packet SHALL be input_link.packet; if output_link.ack is high that cycle the packet is not stored (occupancy stays 0), else it is stored per REQ-015.
REQ-027 Without TIA_LINK_BUFFER_BYPASS_EN, no input-to-output combinational path SHALL exist and REQ-019 latency applies at all occupancies.

Verification
REQ-028 FIFO_DEPTH=3, downstream ack low, push A,B,C,D -> A,B,C accepted, D ack low, occupancy=3, almost_full=1 from occupancy 2.
REQ-029 FIFO_DEPTH=3, continuous push/pop for 10 packets -> output order 0..9, pointers wrap 2->0, occupancy constant 1 after fill.
REQ-030 Occupancy=2, flush pulse one cycle with req high both sides -> no ack, occupancy=0, quiescent=1 next cycle.
REQ-031 Occupancy=2, assert reset asynchronously between edges -> occupancy=0, output_link.req=0 immediately, before next edge.
REQ-032 Bypass defined, empty, push X with downstream ack high -> X on output same cycle, occupancy stays 0; bypass undefined -> X appears cycle N+1.
REQ-033 enable low with req high both sides for 4 cycles -> no acks, no reqs, occupancy unchanged.
